// File: rtl/requantize_pipeline.sv
// Three-stage int32 -> int8 requantizer (saturating doubling high-multiply, rounding shift,
// zero-point add, clamp) with per-layer multiplier/shift fetched from the scale ROM.
module requantize_pipeline #(
    parameter int NUM_LAYERS  = 6,
    parameter int MULT_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    localparam int IDX_WIDTH  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [IDX_WIDTH-1:0]          layer_idx,
    input  logic signed [OUT_WIDTH-1:0]   out_zp,
    input  logic signed [OUT_WIDTH-1:0]   act_min,
    input  logic signed [OUT_WIDTH-1:0]   act_max,
    output logic                          rom_valid,
    output logic [IDX_WIDTH-1:0]          rom_layer_idx,
    input  logic signed [MULT_WIDTH-1:0]  rom_mult,
    input  logic signed [SHIFT_WIDTH-1:0] rom_shift,
    output logic                          params_ready,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [ACC_WIDTH-1:0]   in_acc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data
);

    localparam int PROD_WIDTH = ACC_WIDTH + MULT_WIDTH;
    localparam int LSH_WIDTH  = SHIFT_WIDTH - 1;
    localparam int RSH_WIDTH  = SHIFT_WIDTH + 1;
    localparam int EXT_WIDTH  = ACC_WIDTH + (32'd1 << LSH_WIDTH);

    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_ONE   = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [MULT_WIDTH-1:0] MULT_MIN  = {1'b1, {(MULT_WIDTH-1){1'b0}}};
    localparam logic signed [PROD_WIDTH-1:0] PROD_ONE  = {{(PROD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [PROD_WIDTH-1:0] NUDGE_POS = PROD_ONE <<< (MULT_WIDTH - 2);
    localparam logic signed [PROD_WIDTH-1:0] NUDGE_NEG = PROD_ONE - NUDGE_POS;
    localparam logic signed [PROD_WIDTH-1:0] DIV_BIAS  = (PROD_ONE <<< (MULT_WIDTH - 1)) - PROD_ONE;
    localparam logic [RSH_WIDTH-1:0]         RSH_CAP   = RSH_WIDTH'(ACC_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_REQ = 2'd1,
        ST_LOAD_CAP = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    state_t                        state_r;
    logic signed [MULT_WIDTH-1:0]  mult_r;
    logic [LSH_WIDTH-1:0]          lsh_r;
    logic [RSH_WIDTH-1:0]          rsh_r;
    logic signed [OUT_WIDTH-1:0]   zp_r;
    logic signed [OUT_WIDTH-1:0]   min_r;
    logic signed [OUT_WIDTH-1:0]   max_r;

    logic [RSH_WIDTH-1:0]          neg_shift_s;
    logic [LSH_WIDTH-1:0]          lsh_load_s;
    logic [RSH_WIDTH-1:0]          rsh_load_s;

    logic                          stall_s;
    logic                          pipe_empty_s;
    logic                          reload_s;
    logic                          accept_s;

    logic signed [EXT_WIDTH-1:0]   acc_shl_s;
    logic [EXT_WIDTH-ACC_WIDTH:0]  ovf_hi_s;
    logic signed [ACC_WIDTH-1:0]   a_s;
    logic signed [PROD_WIDTH-1:0]  prod_s;
    logic                          sat_s;
    logic                          v1_r;
    logic signed [PROD_WIDTH-1:0]  p1_r;
    logic                          sat1_r;

    logic signed [PROD_WIDTH-1:0]  rnd_sum_s;
    logic signed [PROD_WIDTH-1:0]  biased_s;
    logic signed [ACC_WIDTH-1:0]   h_s;
    logic                          v2_r;
    logic signed [ACC_WIDTH-1:0]   h2_r;

    logic [ACC_WIDTH-1:0]          mask_s;
    logic [ACC_WIDTH-1:0]          rem_s;
    logic [ACC_WIDTH-1:0]          thr_s;
    logic signed [ACC_WIDTH-1:0]   shr_s;
    logic signed [ACC_WIDTH-1:0]   r_s;
    logic signed [ACC_WIDTH:0]     v_s;
    logic signed [ACC_WIDTH:0]     lo_s;
    logic signed [ACC_WIDTH:0]     hi_s;
    logic signed [OUT_WIDTH-1:0]   q_s;

    // Split the signed ROM shift into left/right amounts; right shifts beyond the word collapse to width-1.
    always_comb begin
        neg_shift_s = -{rom_shift[SHIFT_WIDTH-1], rom_shift};
        if (rom_shift[SHIFT_WIDTH-1]) begin
            lsh_load_s = '0;
            rsh_load_s = (neg_shift_s > RSH_CAP) ? RSH_CAP : neg_shift_s;
        end else begin
            lsh_load_s = rom_shift[LSH_WIDTH-1:0];
            rsh_load_s = '0;
        end
    end

    // Handshake: a stall freezes every stage; a reload start blocks acceptance in that cycle.
    always_comb begin
        stall_s      = out_valid && !out_ready;
        pipe_empty_s = !v1_r && !v2_r && !out_valid;
        reload_s     = (state_r == ST_RUN) && start && pipe_empty_s;
        in_ready     = (state_r == ST_RUN) && !stall_s && !reload_s;
        accept_s     = in_valid && in_ready;
    end

    // Stage 1 datapath: saturating left shift, then the full-width product.
    always_comb begin
        acc_shl_s = {{(EXT_WIDTH-ACC_WIDTH){in_acc[ACC_WIDTH-1]}}, in_acc} <<< lsh_r;
        ovf_hi_s  = acc_shl_s[EXT_WIDTH-1:ACC_WIDTH-1];
        if ((&ovf_hi_s) || !(|ovf_hi_s)) begin
            a_s = acc_shl_s[ACC_WIDTH-1:0];
        end else if (acc_shl_s[EXT_WIDTH-1]) begin
            a_s = ACC_MIN;
        end else begin
            a_s = ACC_MAX;
        end
        prod_s = PROD_WIDTH'(a_s) * PROD_WIDTH'(mult_r);
        sat_s  = (a_s == ACC_MIN) && (mult_r == MULT_MIN);
    end

    // Stage 2 datapath: nudge, then divide by 2^(MULT_WIDTH-1) truncating toward zero.
    always_comb begin
        if (p1_r[PROD_WIDTH-1]) begin
            rnd_sum_s = p1_r + NUDGE_NEG;
        end else begin
            rnd_sum_s = p1_r + NUDGE_POS;
        end
        if (rnd_sum_s[PROD_WIDTH-1]) begin
            biased_s = rnd_sum_s + DIV_BIAS;
        end else begin
            biased_s = rnd_sum_s;
        end
        if (sat1_r) begin
            h_s = ACC_MAX;
        end else begin
            h_s = ACC_WIDTH'(biased_s >>> (MULT_WIDTH - 1));
        end
    end

    // Stage 3 datapath: round-half-away-from-zero right shift, zero point, clamp.
    always_comb begin
        mask_s = (ACC_ONE << rsh_r) - ACC_ONE;
        rem_s  = h2_r & mask_s;
        thr_s  = (mask_s >> 1) + {{(ACC_WIDTH-1){1'b0}}, h2_r[ACC_WIDTH-1]};
        shr_s  = h2_r >>> rsh_r;
        if (rem_s > thr_s) begin
            r_s = shr_s + ACC_ONE;
        end else begin
            r_s = shr_s;
        end
        v_s  = {r_s[ACC_WIDTH-1], r_s} + {{(ACC_WIDTH+1-OUT_WIDTH){zp_r[OUT_WIDTH-1]}}, zp_r};
        lo_s = {{(ACC_WIDTH+1-OUT_WIDTH){min_r[OUT_WIDTH-1]}}, min_r};
        hi_s = {{(ACC_WIDTH+1-OUT_WIDTH){max_r[OUT_WIDTH-1]}}, max_r};
        if (v_s < lo_s) begin
            q_s = min_r;
        end else if (v_s > hi_s) begin
            q_s = max_r;
        end else begin
            q_s = v_s[OUT_WIDTH-1:0];
        end
    end

    // Layer-load FSM with registered ROM request and parameter holding registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            rom_valid     <= 1'b0;
            rom_layer_idx <= '0;
            params_ready  <= 1'b0;
            mult_r        <= '0;
            lsh_r         <= '0;
            rsh_r         <= '0;
            zp_r          <= '0;
            min_r         <= '0;
            max_r         <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        rom_layer_idx <= layer_idx;
                        zp_r          <= out_zp;
                        min_r         <= act_min;
                        max_r         <= act_max;
                        rom_valid     <= 1'b1;
                        state_r       <= ST_LOAD_REQ;
                    end
                end
                ST_LOAD_REQ: begin
                    rom_valid <= 1'b0;
                    state_r   <= ST_LOAD_CAP;
                end
                ST_LOAD_CAP: begin
                    mult_r       <= rom_mult;
                    lsh_r        <= lsh_load_s;
                    rsh_r        <= rsh_load_s;
                    params_ready <= 1'b1;
                    state_r      <= ST_RUN;
                end
                ST_RUN: begin
                    if (reload_s) begin
                        rom_layer_idx <= layer_idx;
                        zp_r          <= out_zp;
                        min_r         <= act_min;
                        max_r         <= act_max;
                        rom_valid     <= 1'b1;
                        params_ready  <= 1'b0;
                        state_r       <= ST_LOAD_REQ;
                    end
                end
                default: begin
                    rom_valid    <= 1'b0;
                    params_ready <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline stage registers; everything holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1_r      <= 1'b0;
            p1_r      <= '0;
            sat1_r    <= 1'b0;
            v2_r      <= 1'b0;
            h2_r      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall_s) begin
            v1_r <= accept_s;
            if (accept_s) begin
                p1_r   <= prod_s;
                sat1_r <= sat_s;
            end
            v2_r <= v1_r;
            if (v1_r) begin
                h2_r <= h_s;
            end
            out_valid <= v2_r;
            if (v2_r) begin
                out_data <= q_s;
            end
        end
    end

endmodule

// File: tb/tb_requantize_pipeline.sv
// Scoreboard bench for requantize_pipeline: ROM model, expected-value queue, latency/hold checks.
module tb_requantize_pipeline;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [2:0]         layer_idx;
    logic signed [7:0]  out_zp, act_min, act_max;
    logic               rom_valid;
    logic [2:0]         rom_layer_idx;
    logic signed [31:0] rom_mult = 32'sd0;
    logic signed [5:0]  rom_shift = 6'sd0;
    logic               params_ready;
    logic               in_valid, in_ready;
    logic signed [31:0] in_acc;
    logic               out_valid, out_ready;
    logic signed [7:0]  out_data;

    requantize_pipeline dut (
        .clk(clk), .reset_n(reset_n), .start(start), .layer_idx(layer_idx),
        .out_zp(out_zp), .act_min(act_min), .act_max(act_max),
        .rom_valid(rom_valid), .rom_layer_idx(rom_layer_idx),
        .rom_mult(rom_mult), .rom_shift(rom_shift), .params_ready(params_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    logic signed [31:0] mult_tbl [0:5];
    logic signed [5:0]  shift_tbl [0:5];
    logic signed [7:0]  exp_q [$];
    int                 cyc_q [$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 rom_pulses = 0;
    bit                 lat_chk = 1'b1;
    bit                 bp_en = 1'b0;
    bit                 held = 1'b0;
    logic signed [7:0]  held_data = 8'sd0;
    logic signed [31:0] cur_mult;
    int                 cur_shift, cur_zp, cur_min, cur_max;

    // Scale ROM: data valid one cycle after the request.
    always @(posedge clk) begin
        if (rom_valid) begin
            rom_mult  <= mult_tbl[rom_layer_idx];
            rom_shift <= shift_tbl[rom_layer_idx];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: TFLite MultiplyByQuantizedMultiplier written with plain integer division.
    function automatic logic signed [7:0] ref_q8(input longint acc, input longint mult, input int shift,
                                                 input int zp, input int mn, input int mx);
        longint a, h, q, r, v;
        int ls, rs;
        ls = (shift > 0) ? shift : 0;
        rs = (shift < 0) ? -shift : 0;
        if (rs > 31) rs = 31;
        a = acc * (64'sd1 << ls);
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        if (a < -64'sd2147483648) a = -64'sd2147483648;
        if (a == -64'sd2147483648 && mult == -64'sd2147483648) h = 64'sd2147483647;
        else begin
            h = a * mult;
            if (h >= 0) h = (h + 64'sd1073741824) / 64'sd2147483648;
            else        h = (h + 64'sd1 - 64'sd1073741824) / 64'sd2147483648;
        end
        if (rs == 0) r = h;
        else begin
            q = (h < 0) ? -h : h;
            q = (q + (64'sd1 << (rs - 1))) >>> rs;
            r = (h < 0) ? -q : q;
        end
        v = r + zp;
        if (v < mn) v = mn;
        if (v > mx) v = mx;
        return v[7:0];
    endfunction

    // Output monitor: pops the scoreboard on each transfer and checks hold under backpressure.
    initial begin
        logic signed [7:0] e;
        int c;
        forever begin
            @(negedge clk);
            if (rom_valid) rom_pulses++;
            if (!reset_n) held = 1'b0;
            else begin
                if (held) begin
                    chk_val("hold_valid", out_valid, 1);
                    chk_val("hold_data", out_data, held_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk_val("unexpected_out_valid", out_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        c = cyc_q.pop_front();
                        chk_val("out_data", out_data, e);
                        if (lat_chk) chk_val("latency", cyc - c, 3);
                    end
                end
                held      = out_valid && !out_ready;
                held_data = out_data;
            end
        end
    end

    // Random output backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic load(input int idx, input int zp, input int mn, input int mx);
        int p0;
        p0 = rom_pulses;
        start = 1'b1; layer_idx = 3'(idx);
        out_zp = 8'(zp); act_min = 8'(mn); act_max = 8'(mx);
        @(posedge clk); #1;
        start = 1'b0;
        chk_val("ld_rom_valid_t1", rom_valid, 1);
        chk_val("ld_rom_idx_t1", rom_layer_idx, idx);
        chk_val("ld_params_ready_t1", params_ready, 0);
        @(posedge clk); #1;
        chk_val("ld_rom_valid_t2", rom_valid, 0);
        chk_val("ld_params_ready_t2", params_ready, 0);
        chk_val("ld_in_ready_t2", in_ready, 0);
        @(posedge clk); #1;
        chk_val("ld_params_ready_t3", params_ready, 1);
        chk_val("ld_in_ready_t3", in_ready, 1);
        chk_val("ld_rom_pulses", rom_pulses - p0, 1);
        cur_mult = mult_tbl[idx]; cur_shift = int'(shift_tbl[idx]);
        cur_zp = zp; cur_min = mn; cur_max = mx;
    endtask

    task automatic send(input int acc, input logic signed [7:0] e);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_acc = acc;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) begin
                exp_q.push_back(e);
                cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk_val("accept_timeout", in_ready, 1);
    endtask

    task automatic send_ref(input int acc);
        send(acc, ref_q8(longint'(acc), longint'(cur_mult), cur_shift, cur_zp, cur_min, cur_max));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        chk_val("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_val({tag, "_rom_valid"}, rom_valid, 0);
        chk_val({tag, "_rom_layer_idx"}, rom_layer_idx, 0);
        chk_val({tag, "_params_ready"}, params_ready, 0);
        chk_val({tag, "_in_ready"}, in_ready, 0);
        chk_val({tag, "_out_valid"}, out_valid, 0);
        chk_val({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        mult_tbl[0] = 32'sh4000_0000; shift_tbl[0] = 6'sd0;
        mult_tbl[1] = 32'sh4000_0000; shift_tbl[1] = -6'sd1;
        mult_tbl[2] = 32'sh4000_0000; shift_tbl[2] = 6'sd2;
        mult_tbl[3] = 32'sh8000_0000; shift_tbl[3] = 6'sd0;
        mult_tbl[4] = 32'sd1234567890; shift_tbl[4] = -6'sd25;
        mult_tbl[5] = 32'sh7fff_ffff; shift_tbl[5] = -6'sd32;
        reset_n = 1'b0; start = 1'b0; layer_idx = 3'd0;
        out_zp = 8'sd0; act_min = -8'sd128; act_max = 8'sd127;
        in_valid = 1'b0; in_acc = 32'sd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Load sequence on layer 2; left shift saturates, result clamps.
        load(2, 0, -128, 127);
        send(32'sh4000_0000, 8'sd127);
        drain();

        // Rounding and latency, back-to-back beats.
        load(0, 0, -128, 127);
        send(100, 8'sd50);
        send(101, 8'sd51);
        send(-101, -8'sd50);
        send(10000, 8'sd127);
        drain();

        load(1, 0, -128, 127);
        send(101, 8'sd26);
        drain();

        load(0, -128, -128, 127);
        send(100, -8'sd78);
        drain();

        load(3, 0, -128, 127);
        send(32'sh8000_0000, 8'sd127);
        send(1, -8'sd1);
        drain();

        load(0, 0, 0, 127);
        send(-101, 8'sd0);
        drain();

        // Start with a beat still in flight must be ignored.
        out_ready = 1'b0;
        send(101, 8'sd51);
        start = 1'b1; layer_idx = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        chk_val("busy_start_rom_valid", rom_valid, 0);
        chk_val("busy_start_params_ready", params_ready, 1);
        @(posedge clk); #1;
        chk_val("busy_start_rom_valid_t2", rom_valid, 0);
        out_ready = 1'b1;
        drain();

        // Backpressure with random accumulators.
        load(4, 5, -100, 100);
        lat_chk = 1'b0;
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++) send_ref(int'($urandom()));
        drain();
        bp_en = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Right shift beyond the word width collapses to 31.
        load(5, 0, -128, 127);
        send_ref(32'sh7fff_ffff);
        send_ref(32'sh8000_0000);
        send_ref(32'sh4000_0000);
        send_ref(-32'sh4000_0001);
        drain();
        lat_chk = 1'b1;

        // Reset with three beats in flight.
        load(0, 0, -128, 127);
        out_ready = 1'b0;
        send(100, 8'sd50);
        send(101, 8'sd51);
        send(-101, -8'sd50);
        reset_n = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_reset_outputs("midreset");
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        load(0, 0, -128, 127);
        send(100, 8'sd50);
        drain();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
